controlador_servo: RTL and testbench

CONTROLADOR_SERVO -- requirements
Module: controlador_servo

---
 rtl/controlador_servo.sv | 138 +++++++++++++
 tb/tb_controlador_servo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/controlador_servo.sv
// rtl/controlador_servo.sv - servo position sequencer with settle wait
//
// Purpose: accepts a move request while idle, drives the position select to
// the downstream PWM generator, waits TEMPO_ESPERA cycles for the servo to
// settle and pulses pronto on completion.
//
// Optional feature: define CONTROLADOR_SERVO_RETORNO_EN to make an actuated
// move (largura=1) return automatically to home after its settle wait,
// followed by a second settle wait.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   iniciar  in   move request, sampled only while idle
//   posicao  in   target position (0 = home, 1 = actuated), sampled with iniciar
//   largura  out  registered position select for the PWM generator
//   ocupado  out  registered, high while a move is in progress
//   pronto   out  registered, one-cycle pulse at move completion

module controlador_servo #(
  parameter logic [31:0] TEMPO_ESPERA = 32'd25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic iniciar,
  input  logic posicao,
  output logic largura,
  output logic ocupado,
  output logic pronto
);

  localparam logic [31:0] ULTIMO = TEMPO_ESPERA - 32'd1;

`ifdef CONTROLADOR_SERVO_RETORNO_EN
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESPERA  = 2'd1,
    FIM     = 2'd2,
    RETORNO = 2'd3
  } estado_t;
`else
  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ESPERA = 2'd1,
    FIM    = 2'd2
  } estado_t;
`endif

  estado_t     estado, prox_estado;
  logic [31:0] contador, prox_contador;
  logic        prox_largura, prox_ocupado, prox_pronto;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= OCIOSO;
      contador <= 32'd0;
      largura  <= 1'b0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
    end else begin
      estado   <= prox_estado;
      contador <= prox_contador;
      largura  <= prox_largura;
      ocupado  <= prox_ocupado;
      pronto   <= prox_pronto;
    end
  end

  // Every output is a registered copy of its next value, so largura can only
  // change on a clock edge and never glitches toward the PWM generator.
  always_comb begin
    prox_estado   = estado;
    prox_contador = contador;
    prox_largura  = largura;
    prox_ocupado  = ocupado;
    prox_pronto   = pronto;

    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          prox_estado   = ESPERA;
          prox_largura  = posicao;
          prox_contador = 32'd0;
          prox_ocupado  = 1'b1;
        end
      end

      ESPERA: begin
        // Advancing on the last count (instead of counting once more) makes
        // the wait exactly TEMPO_ESPERA cycles long.
        if (contador == ULTIMO) begin
          prox_contador = 32'd0;
`ifdef CONTROLADOR_SERVO_RETORNO_EN
          if (largura) begin
            prox_estado  = RETORNO;
            prox_largura = 1'b0;
          end else begin
            prox_estado = FIM;
            prox_pronto = 1'b1;
          end
`else
          prox_estado = FIM;
          prox_pronto = 1'b1;
`endif
        end else begin
          prox_contador = contador + 32'd1;
        end
      end

`ifdef CONTROLADOR_SERVO_RETORNO_EN
      RETORNO: begin
        if (contador == ULTIMO) begin
          prox_contador = 32'd0;
          prox_estado   = FIM;
          prox_pronto   = 1'b1;
        end else begin
          prox_contador = contador + 32'd1;
        end
      end
`endif

      FIM: begin
        // Requests arriving here are dropped; nothing is queued.
        prox_estado  = OCIOSO;
        prox_pronto  = 1'b0;
        prox_ocupado = 1'b0;
      end

      default: begin
        prox_estado   = OCIOSO;
        prox_contador = 32'd0;
        prox_ocupado  = 1'b0;
        prox_pronto   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_controlador_servo.sv
// tb/tb_controlador_servo.sv - self-checking bench for controlador_servo

module tb_controlador_servo;

  localparam int T = 4;

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic iniciar = 1'b0;
  logic posicao = 1'b0;
  logic largura, ocupado, pronto;

  controlador_servo #(.TEMPO_ESPERA(32'd4)) dut (
    .clock   (clock),
    .reset   (reset),
    .iniciar (iniciar),
    .posicao (posicao),
    .largura (largura),
    .ocupado (ocupado),
    .pronto  (pronto)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic l;
    logic o;
    logic p;
  } saida_t;

  // Expected outputs after each future edge of an accepted move.
  saida_t linha[$];
  logic   m_larg = 1'b0;
  int     tests  = 0;
  int     fails  = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    linha.delete();
    m_larg = 1'b0;
  endtask

  // A move: settle at the target, optionally settle again at home, then one
  // completion cycle, then one cycle in which the returning edge ignores input.
  task automatic plan_move(input logic pos);
    logic fim_l;
    fim_l = pos;
    for (int i = 0; i < T; i++) linha.push_back({pos, 1'b1, 1'b0});
`ifdef CONTROLADOR_SERVO_RETORNO_EN
    if (pos) begin
      for (int i = 0; i < T; i++) linha.push_back({1'b0, 1'b1, 1'b0});
      fim_l = 1'b0;
    end
`endif
    linha.push_back({fim_l, 1'b1, 1'b1});
    linha.push_back({fim_l, 1'b0, 1'b0});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_largura"}, largura, 1'b0);
    check({tag, "_ocupado"}, ocupado, 1'b0);
    check({tag, "_pronto"},  pronto,  1'b0);
  endtask

  task automatic cycle();
    saida_t e;
    @(posedge clock);
    #1;
    if (!reset) begin
      model_reset();
    end else if (linha.size() == 0 && iniciar) begin
      plan_move(posicao);
    end
    if (linha.size() != 0) begin
      e = linha.pop_front();
      m_larg = e.l;
    end else begin
      e = {m_larg, 1'b0, 1'b0};
    end
    check("largura", largura, e.l);
    check("ocupado", ocupado, e.o);
    check("pronto",  pronto,  e.p);
  endtask

  task automatic idle(input int n);
    iniciar = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int n_pronto;

    // Reset state, then a request honoured on the very first edge.
    #3;
    check_zero("reset_state");
    #4;
    reset   = 1'b1;
    iniciar = 1'b1;
    posicao = 1'b1;
    cycle();
    check("first_edge_ocupado", ocupado, 1'b1);
    iniciar = 1'b0;
    idle(3 * T);

    // Idle -> move with explicit pronto latency.
    iniciar = 1'b1;
    posicao = 1'b1;
    n_pronto = 0;
    for (int i = 0; i < 3 * T + 2; i++) begin
      cycle();
      iniciar = 1'b0;
      if (pronto) n_pronto++;
`ifndef CONTROLADOR_SERVO_RETORNO_EN
      if (i == T) check("pronto_edge5", pronto, 1'b1);
`else
      if (i == 2 * T) check("pronto_edge9", pronto, 1'b1);
`endif
    end
    check_int("move_pronto_count", n_pronto, 1);

    // Requests during the wait and during the completion cycle are dropped.
    n_pronto = 0;
    for (int i = 0; i < 3 * T + 4; i++) begin
      iniciar = (i == 0) || (i == 2) || (i == T + 1);
      posicao = (i == 0);
      cycle();
      if (pronto) n_pronto++;
    end
    check_int("busy_pronto_count", n_pronto, 1);

    // Reset in the second wait cycle: outputs clear without a clock edge.
    iniciar = 1'b1;
    posicao = 1'b1;
    cycle();
    iniciar = 1'b0;
    cycle();
    #2;
    reset = 1'b0;
    #1;
    check_zero("rst_async");
    model_reset();
    cycle();
    #2;
    reset = 1'b1;
    n_pronto = 0;
    for (int i = 0; i < 2 * T + 2; i++) begin
      cycle();
      if (pronto) n_pronto++;
    end
    check_int("lost_pronto_count", n_pronto, 0);
    iniciar = 1'b1;
    posicao = 1'b1;
    cycle();
    idle(3 * T);

    // Move home, then a redundant home move still waits and completes.
    for (int k = 0; k < 2; k++) begin
      iniciar = 1'b1;
      posicao = 1'b0;
      cycle();
      idle(T + 2);
    end

    // Held request: back-to-back moves with one idle cycle between them.
    iniciar = 1'b1;
    posicao = 1'b1;
    for (int i = 0; i < 3 * (2 * T + 2); i++) cycle();
    idle(3 * T);

    // Random traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      iniciar = ($urandom_range(0, 3) == 0);
      posicao = 1'($urandom_range(0, 1));
      cycle();
      if ($urandom_range(0, 59) == 0) begin
        #1;
        reset = 1'b0;
        #1;
        check_zero("rand_rst_async");
        model_reset();
        #1;
        reset = 1'b1;
      end
    end
    idle(3 * T);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
